// File: rtl/jtopl_reg_wr.sv
// rtl/jtopl_reg_wr.sv - OPL operator register write sequencer; JTOPL_WR_BUSY_EN makes data writes during busy ignored instead of replacing.
module jtopl_reg_wr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       update_op_I,
    output logic       update_op_II,
    output logic       update_op_IV,
    output logic [4:0] slot,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_I  = 2'd1,
        S_WAIT_IV = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [7:0] addr_q;
    logic [4:0] grp_q;
    logic [4:0] target_q;
    logic [4:0] grp_dec;
    logic [4:0] target_dec;
    logic       target_ok;
    logic [4:0] target_p1;
    logic [4:0] target_p3;
    logic       addr_wr;
    logic       data_wr;
    logic       accept;
    logic       fire_ok;

    assign addr_wr = !wr_n && !addr;
    assign data_wr = !wr_n && addr;

    // Group one-hot: {wav, sl_rr, ar_dr, ksl_tl, mult}
    always_comb begin
        grp_dec = 5'b00000;
        case (addr_q[7:4])
            4'h2, 4'h3: grp_dec = 5'b00001;
            4'h4, 4'h5: grp_dec = 5'b00010;
            4'h6, 4'h7: grp_dec = 5'b00100;
            4'h8, 4'h9: grp_dec = 5'b01000;
            4'hE, 4'hF: grp_dec = 5'b10000;
            default:    grp_dec = 5'b00000;
        endcase
    end

    // Offsets come in three banks of six operators: slot = bank*6 + index
    always_comb begin
        target_ok  = (addr_q[2:0] <= 3'd5) && (addr_q[4:3] != 2'b11);
        target_dec = {1'b0, addr_q[4:3], 2'b00}
                   + {2'b00, addr_q[4:3], 1'b0}
                   + {2'b00, addr_q[2:0]};
    end

`ifdef JTOPL_WR_BUSY_EN
    assign accept = data_wr && target_ok && (grp_dec != 5'b00000) && (state == S_IDLE);
`else
    assign accept = data_wr && target_ok && (grp_dec != 5'b00000);
`endif

    always_comb begin
        target_p1 = (target_q == 5'd17) ? 5'd0 : target_q + 5'd1;
        target_p3 = (target_q >= 5'd15) ? target_q - 5'd15 : target_q + 5'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = S_WAIT_I;
        end else begin
            case (state)
                S_WAIT_I:  if (update_op_I)  state_nx = S_WAIT_IV;
                S_WAIT_IV: if (update_op_IV) state_nx = S_IDLE;
                default:   state_nx = state;
            endcase
        end
    end

    // A write landing this clk restarts the sequence, so nothing may fire on it
    always_comb begin
        fire_ok      = cen && !accept;
        update_op_I  = fire_ok && (state == S_WAIT_I)  && (slot == target_q);
        update_op_II = fire_ok && (state == S_WAIT_IV) && (slot == target_p1);
        update_op_IV = fire_ok && (state == S_WAIT_IV) && (slot == target_p3);
`ifdef JTOPL_WR_BUSY_EN
        busy = (state != S_IDLE);
`else
        busy = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= 8'd0;
            dout     <= 8'd0;
            grp_q    <= 5'd0;
            target_q <= 5'd0;
            slot     <= 5'd0;
        end else begin
            if (addr_wr) begin
                addr_q <= din;
            end
            if (accept) begin
                dout     <= din;
                grp_q    <= grp_dec;
                target_q <= target_dec;
            end else if (update_op_IV) begin
                grp_q <= 5'd0;
            end
            if (cen) begin
                slot <= (slot == 5'd17) ? 5'd0 : slot + 5'd1;
            end
        end
    end

    assign up_mult   = grp_q[0];
    assign up_ksl_tl = grp_q[1];
    assign up_ar_dr  = grp_q[2];
    assign up_sl_rr  = grp_q[3];
    assign up_wav    = grp_q[4];

endmodule

// File: tb/tb_jtopl_reg_wr.sv
// tb/tb_jtopl_reg_wr.sv - scoreboard bench for jtopl_reg_wr strobe sequencing.
module tb_jtopl_reg_wr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic       wr_n = 1'b1;
    logic       addr = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
    logic       update_op_I, update_op_II, update_op_IV;
    logic [4:0] slot;
    logic       busy;

    jtopl_reg_wr dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr_n(wr_n), .addr(addr), .din(din),
        .dout(dout), .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
        .up_sl_rr(up_sl_rr), .up_wav(up_wav), .update_op_I(update_op_I),
        .update_op_II(update_op_II), .update_op_IV(update_op_IV), .slot(slot), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef JTOPL_WR_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    localparam logic [4:0] G_MULT = 5'b00001;
    localparam logic [4:0] G_KSL  = 5'b00010;
    localparam logic [4:0] G_AR   = 5'b00100;
    localparam logic [4:0] G_SL   = 5'b01000;
    localparam logic [4:0] G_WAV  = 5'b10000;

    typedef struct {
        logic [2:0] op;
        logic [4:0] slot;
        logic [4:0] up;
    } ev_t;

    ev_t        exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [4:0] slot_m = 5'd0;
    bit         mon_en = 1'b0;

    wire [4:0] up_v = {up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
    wire [2:0] op_v = {update_op_IV, update_op_II, update_op_I};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] up, input int s1, input int s2, input int s4);
        exp_q.push_back('{3'b001, 5'(s1), up});
        exp_q.push_back('{3'b010, 5'(s2), up});
        exp_q.push_back('{3'b100, 5'(s4), up});
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        wr_n = 1'b0;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        wr_n = 1'b1;
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        while (32'(slot_m) != s && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (32'(slot_m) != s) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_slot: got slot %0d expected %0d", slot_m, s);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d strobes outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
        chk({name, "_up_clear"}, 32'(up_v), 32'd0);
        chk({name, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    task automatic seq(input logic [7:0] a, input logic [7:0] d, input logic [4:0] up,
                       input int s1, input int s2, input int s4, input string name);
        wr(1'b0, a);
        push(up, s1, s2, s4);
        wr(1'b1, d);
        chk({name, "_dout"}, 32'(dout), 32'(d));
        chk({name, "_up"}, 32'(up_v), 32'(up));
        chk({name, "_busy"}, 32'(busy), 32'(BUSY_EN));
        wait_done(name);
        chk({name, "_dout_kept"}, 32'(dout), 32'(d));
    endtask

    always @(posedge clk) begin
        if (!rst_n)   slot_m <= 5'd0;
        else if (cen) slot_m <= (slot_m == 5'd17) ? 5'd0 : slot_m + 5'd1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            ev_t e;
            chk("slot", 32'(slot), 32'(slot_m));
            if (op_v != 3'b000) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got op=%b at slot %0d expected none", op_v, slot);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_op", 32'(op_v), 32'(e.op));
                    chk("strobe_slot", 32'(slot), 32'(e.slot));
                    chk("strobe_up", 32'(up_v), 32'(e.up));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_up", 32'(up_v), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_strobes", 32'(op_v), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        wait_slot(4); seq(8'h20, 8'h81, G_MULT, 0, 1, 3, "mult_t0");
        wait_slot(4); seq(8'h55, 8'h3F, G_KSL, 17, 0, 2, "ksl_t17");
        wait_slot(4); seq(8'h88, 8'h5A, G_SL, 6, 7, 9, "best_case");
        wait_slot(5); seq(8'h48, 8'hC3, G_KSL, 6, 7, 9, "worst_case");
        wait_slot(0); seq(8'hF4, 8'h7E, G_WAV, 16, 17, 1, "wav_t16");
        wait_slot(0); seq(8'h2D, 8'hA5, G_MULT, 11, 12, 14, "mult_t11");

        wr(1'b0, 8'h26); wr(1'b1, 8'h11);
        chk("bad_off_up", 32'(up_v), 32'd0);
        chk("bad_off_busy", 32'(busy), 32'd0);
        chk("bad_off_dout", 32'(dout), 32'hA5);
        wr(1'b0, 8'hA0); wr(1'b1, 8'h11);
        chk("bad_grp_up", 32'(up_v), 32'd0);
        chk("bad_grp_dout", 32'(dout), 32'hA5);
        wr(1'b0, 8'h3E); wr(1'b1, 8'h11);
        chk("bad_bank_up", 32'(up_v), 32'd0);
        chk("bad_bank_dout", 32'(dout), 32'hA5);
        repeat (40) @(posedge clk);
        #1;

        wait_slot(1);
        wr(1'b0, 8'hE0);
        push(G_WAV, 0, 1, 3);
        wr(1'b1, 8'h02);
        wr(1'b0, 8'h80);
        if (!BUSY_EN) begin
            exp_q.delete();
            push(G_SL, 0, 1, 3);
        end
        wr(1'b1, 8'h44);
        chk("busy_wr_dout", 32'(dout), BUSY_EN ? 32'h02 : 32'h44);
        chk("busy_wr_up", 32'(up_v), BUSY_EN ? 32'(G_WAV) : 32'(G_SL));
        wait_done("busy_wr");
        chk("busy_wr_dout_kept", 32'(dout), BUSY_EN ? 32'h02 : 32'h44);

        wait_slot(4);
        wr(1'b0, 8'h68);
        push(G_AR, 6, 7, 9);
        wr(1'b1, 8'h5A);
        cen = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("frozen_slot", 32'(slot), 32'd6);
        chk("frozen_pending", 32'(exp_q.size()), 32'd3);
        chk("frozen_up", 32'(up_v), 32'(G_AR));
        cen = 1'b1;
        wait_done("cen_hold");

        wait_slot(4);
        wr(1'b0, 8'h40);
        wr(1'b1, 8'h77);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        wr_n  = 1'b0;
        addr  = 1'b1;
        din   = 8'h55;
        @(posedge clk);
        #1;
        wr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_up", 32'(up_v), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_slot", 32'(slot), 32'd0);
        chk("midrst_strobes", 32'(op_v), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("postrst_up", 32'(up_v), 32'd0);
        wr(1'b1, 8'h99);
        chk("postrst_addr_cleared_dout", 32'(dout), 32'd0);
        chk("postrst_addr_cleared_up", 32'(up_v), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtopl_reg_wr.md
JTOPL_REG_WR -- requirements
Module: jtopl_reg_wr

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cen  in  1  slot-advance clock enable
- wr_n  in  1  CPU write strobe, active-low, one clk per write
- addr  in  1  0 = address port, 1 = data port
- din  in  8  CPU data
- dout  out  8  held data byte for the operator CSR
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav  out  1 each  register-group select, level while pending
- update_op_I, update_op_II, update_op_IV  out  1 each  slot-match strobes
- slot  out  5  current slot number, 0..17
- busy  out  1  write pending

Function
REQ-003 SHALL latch din into an 8-bit address register on a wr_n=0 clk with addr=0; busy SHALL be unaffected.
REQ-004 On a wr_n=0 clk with addr=1, SHALL decode the latched address high bits as a register group:
- 0x2x/0x3x = mult
- 0x4x/0x5x = ksl_tl
- 0x6x/0x7x = ar_dr
- 0x8x/0x9x = sl_rr
- 0xEx/0xFx = wav
REQ-005 SHALL map the operator offset (address & 0x1F) to a target slot:
- 0x00-0x05 -> 0-5
- 0x08-0x0D -> 6-11
- 0x10-0x15 -> 12-17
- other offsets, and addresses outside the REQ-004 groups, SHALL be ignored with no state change.
REQ-006 A valid data write SHALL load dout=din, set exactly one up_* output and set busy=1 on the next clk.
REQ-007 slot SHALL increment on each clk with cen=1 and wrap 17->0; it SHALL hold while cen=0.
REQ-008 While busy, update strobes (combinational, qualified by cen) SHALL assert as follows:
- update_op_I when slot==target
- update_op_II when slot==(target+1) mod 18
- update_op_IV when slot==(target+3) mod 18
- each strobe SHALL be high for exactly one cen cycle per write.
REQ-009 Strobe eligibility SHALL begin on the first cen strictly after busy rises; a match in the write clk itself SHALL NOT fire.
REQ-010 On the cen cycle that fires update_op_IV, SHALL clear busy and all up_* outputs on the following clk; dout SHALL keep its value.
REQ-011 Worst-case write-to-completion SHALL be 21 cen cycles; best case SHALL be 4 cen cycles.
REQ-012 Wrap-around: target 16 or 17 SHALL produce update_op_II/IV at slots 17/1 and 0/2 respectively.
REQ-013 If an address write and cen coincide, both SHALL take effect in the same clk.

Reset
REQ-014 With rst_n=0 at a clk edge, the block SHALL set:
- address register, dout, slot to 0
- busy, all up_* and all update_op_* to 0
- any pending write discarded.
REQ-015 Reset SHALL take priority over a simultaneous CPU write or cen.

Configuration
REQ-016 Macro JTOPL_WR_BUSY_EN SHALL select how a data write during busy=1 is handled.
REQ-017 With JTOPL_WR_BUSY_EN defined:
- a data write while busy SHALL be ignored
- address writes SHALL still latch
- busy SHALL be driven as in REQ-006/REQ-010.
REQ-018 Without JTOPL_WR_BUSY_EN:
- a valid data write while busy SHALL replace the pending write (new dout, group, target)
- strobe sequencing SHALL restart per REQ-009
- the busy port SHALL be tied 0, with internal pending tracking unchanged.

Verification
REQ-019 Reset: rst_n=0 for 2 clk mid-pending -> all outputs 0 and slot=0 next clk.
REQ-020 Write addr 0x20, data 0x81 at slot 5 -> dout=0x81 and up_mult=1, then:
- update_op_I at slot 0
- update_op_II at slot 1
- update_op_IV at slot 3
- busy=0 the clk after slot 3.
REQ-021 Write addr 0x55, data 0x3F -> target 17:
- update_op_I at slot 17
- update_op_II at slot 0
- update_op_IV at slot 2
- up_ksl_tl=1 throughout.
REQ-022 Write addr 0x26 or 0xA0 with data 0x11 -> no up_*, busy stays 0, dout unchanged.
REQ-023 Write 0xE0/0x02 then, while busy, 0x80/0x44:
- with JTOPL_WR_BUSY_EN: dout=0x02, only up_wav sequence
- without: dout=0x44, up_sl_rr sequence restarted.
REQ-024 cen held 0 for 50 clk while busy -> slot frozen and no strobes; sequence resumes when cen returns.
